// File: rtl/gray_pkg.sv
// gray_pkg: shared state encoding and control constants for the Gray sequencer
package gray_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic DIR_DOWN     = 1'b0;
    localparam logic DIR_UP       = 1'b1;
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
endpackage

// File: rtl/gray_enc.sv
// gray_enc: combinational binary-to-Gray encoder
module gray_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: steps a binary count and streams it as Gray code over valid/ready
module gray_seq_ctrl
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_gray,
    output logic [WIDTH-1:0] out_bin,
    output logic             busy,
    output logic             done
);
    state_t           state;
    logic [WIDTH-1:0] count;
    logic             lat_dir;
    logic             lat_mode;
    logic [WIDTH-1:0] lat_limit;
    logic [WIDTH-1:0] term;
    logic             at_term;
    logic             xfer;

    assign term    = (lat_dir == DIR_UP) ? lat_limit : '0;
    assign at_term = (count == term);
    assign xfer    = out_valid && out_ready;
    assign busy    = (state == RUN);
    assign out_bin = count;

    gray_enc #(.WIDTH(WIDTH)) u_enc (
        .bin  (count),
        .gray (out_gray)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            lat_dir   <= 1'b0;
            lat_mode  <= 1'b0;
            lat_limit <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && !stop) begin
                    state     <= RUN;
                    lat_dir   <= dir;
                    lat_mode  <= mode;
                    lat_limit <= limit;
                    count     <= (dir == DIR_UP) ? '0 : limit;
                    out_valid <= 1'b1;
                end
            end else if (stop) begin
                // a beat transferring alongside stop is delivered; nothing follows it
                state     <= IDLE;
                out_valid <= 1'b0;
            end else if (xfer) begin
                if (at_term && lat_mode == MODE_ONESHOT) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    done      <= 1'b1;
                end else if (at_term) begin
                    count <= (lat_dir == DIR_UP) ? '0 : lat_limit;
                end else begin
                    count <= (lat_dir == DIR_UP) ? count + 1'b1 : count - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: directed self-checking bench for gray_seq_ctrl
module tb_gray_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] limit = '0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] out_gray;
    logic [3:0] out_bin;
    logic       busy;
    logic       done;
    int         n_checks = 0;
    int         n_fail = 0;

    gray_seq_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .dir       (dir),
        .mode      (mode),
        .limit     (limit),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_gray  (out_gray),
        .out_bin   (out_bin),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // issue start at the current falling edge; returns at the falling edge of the first beat
    task automatic kick(input logic d, input logic m, input logic [3:0] l);
        start = 1'b1;
        dir   = d;
        mode  = m;
        limit = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, busy, done, out_gray, out_bin} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset: got v=%b b=%b d=%b g=%h bin=%h, want all 0", out_valid, busy, done, out_gray, out_bin);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_oneshot_up;
        logic [3:0] exp_g [6] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7};
        out_ready = 1'b1;
        kick(1'b1, 1'b1, 4'd5);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({out_valid, busy, done, out_gray} !== {3'b110, exp_g[i]}) begin
                n_fail++;
                $display("FAIL oneshot_up beat %0d: got v=%b b=%b d=%b g=%h, want v=1 b=1 d=0 g=%h", i, out_valid, busy, done, out_gray, exp_g[i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({out_valid, busy, done} !== 3'b001) begin
            n_fail++;
            $display("FAIL oneshot_up end: got v=%b b=%b d=%b, want v=0 b=0 d=1", out_valid, busy, done);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_up done_width: got d=%b, want 0", done);
        end
    endtask

    task automatic test_wrap_down;
        logic [3:0] exp_b [8] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
        logic [3:0] exp_g [8] = '{4'd2, 4'd3, 4'd1, 4'd0, 4'd2, 4'd3, 4'd1, 4'd0};
        out_ready = 1'b1;
        kick(1'b0, 1'b0, 4'd3);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({out_valid, done, out_bin, out_gray} !== {2'b10, exp_b[i], exp_g[i]}) begin
                n_fail++;
                $display("FAIL wrap_down beat %0d: got v=%b d=%b bin=%h g=%h, want v=1 d=0 bin=%h g=%h", i, out_valid, done, out_bin, out_gray, exp_b[i], exp_g[i]);
            end
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL wrap_down stop: got v=%b b=%b d=%b, want 000", out_valid, busy, done);
        end
    endtask

    task automatic test_backpressure;
        logic       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_b [12] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5};
        logic [3:0] exp_g [12] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd3, 4'd2, 4'd2, 4'd2, 4'd6, 4'd7, 4'd7, 4'd7};
        out_ready = 1'b1;
        kick(1'b1, 1'b0, 4'd7);
        for (int i = 0; i < 12; i++) begin
            out_ready = pat[i % 4];
            n_checks++;
            if ({out_valid, out_bin, out_gray} !== {1'b1, exp_b[i], exp_g[i]}) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: got v=%b bin=%h g=%h, want v=1 bin=%h g=%h", i, out_valid, out_bin, out_gray, exp_b[i], exp_g[i]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_stop;
        out_ready = 1'b1;
        kick(1'b1, 1'b0, 4'd9);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({out_valid, out_bin} !== {1'b1, 4'(i)}) begin
                n_fail++;
                $display("FAIL stop beat %0d: got v=%b bin=%h, want v=1 bin=%h", i, out_valid, out_bin, 4'(i));
            end
            if (i == 2) stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        n_checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL stop after: got v=%b b=%b d=%b, want 000", out_valid, busy, done);
        end
        kick(1'b1, 1'b0, 4'd9);
        n_checks++;
        if ({out_valid, busy, out_bin} !== {2'b11, 4'd0}) begin
            n_fail++;
            $display("FAIL stop restart: got v=%b b=%b bin=%h, want v=1 b=1 bin=0", out_valid, busy, out_bin);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_limit0;
        out_ready = 1'b1;
        kick(1'b1, 1'b1, 4'd0);
        n_checks++;
        if ({out_valid, done, out_gray} !== {2'b10, 4'd0}) begin
            n_fail++;
            $display("FAIL limit0 beat: got v=%b d=%b g=%h, want v=1 d=0 g=0", out_valid, done, out_gray);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy, done} !== 3'b001) begin
            n_fail++;
            $display("FAIL limit0 done: got v=%b b=%b d=%b, want v=0 b=0 d=1", out_valid, busy, done);
        end
        kick(1'b0, 1'b1, 4'd0);
        n_checks++;
        if ({out_valid, done, out_bin} !== {2'b10, 4'd0}) begin
            n_fail++;
            $display("FAIL limit0 restart_on_done: got v=%b d=%b bin=%h, want v=1 d=0 bin=0", out_valid, done, out_bin);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_start_stop_idle;
        stop = 1'b1;
        kick(1'b1, 1'b0, 4'd5);
        stop = 1'b0;
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_stop_idle: got v=%b b=%b, want 00", out_valid, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_start_busy;
        out_ready = 1'b1;
        kick(1'b1, 1'b1, 4'd7);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({out_valid, out_bin} !== {1'b1, 4'(i)}) begin
                n_fail++;
                $display("FAIL start_busy beat %0d: got v=%b bin=%h, want v=1 bin=%h", i, out_valid, out_bin, 4'(i));
            end
            start = (i == 2);
            dir   = (i == 2) ? 1'b0 : 1'b1;
            limit = (i == 2) ? 4'd3 : 4'd7;
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if ({out_valid, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL start_busy end: got v=%b d=%b, want v=0 d=1", out_valid, done);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid;
        logic [3:0] exp_g [3] = '{4'd0, 4'd1, 4'd3};
        out_ready = 1'b1;
        kick(1'b1, 1'b1, 4'd9);
        repeat (4) @(negedge clk);
        n_checks++;
        if (out_bin !== 4'd4) begin
            n_fail++;
            $display("FAIL rst_mid pre: got bin=%h, want 4", out_bin);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({out_valid, busy, done, out_gray, out_bin} !== 11'd0) begin
            n_fail++;
            $display("FAIL rst_mid after: got v=%b b=%b d=%b g=%h bin=%h, want all 0", out_valid, busy, done, out_gray, out_bin);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid no_done: got d=%b, want 0", done);
        end
        kick(1'b1, 1'b1, 4'd2);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({out_valid, out_gray} !== {1'b1, exp_g[i]}) begin
                n_fail++;
                $display("FAIL rst_mid fresh beat %0d: got v=%b g=%h, want v=1 g=%h", i, out_valid, out_gray, exp_g[i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({out_valid, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_mid fresh done: got v=%b d=%b, want v=0 d=1", out_valid, done);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_oneshot_up();
        test_wrap_down();
        test_backpressure();
        test_stop();
        test_limit0();
        test_start_stop_idle();
        test_start_busy();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
